// File: rtl/alu_arbiter_pkg.sv
// Shared CPU types for the ALU arbiter: ALU opcode, data word and arbiter FSM states.
package alu_arbiter_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } aluop_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NREQ.
module alu_arbiter_rr_picker #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx
);

    int unsigned j;
    logic        found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            // Modulo keeps the scan inside 0..NREQ-1 even for non-power-of-2 NREQ.
            j = (32'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU: IDLE accepts, EXEC drives the ALU, RESP holds result.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned WORD = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*4-1:0]   req_op,
    input  logic [NREQ*32-1:0]  req_a,
    input  logic [NREQ*32-1:0]  req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [WORD-1:0]     rsp_result,
    output logic                rsp_zero,
    output logic                rsp_neg,
    output logic                rsp_ovf,
    output logic                busy,
    output logic [3:0]          alu_aluop,
    output logic [WORD-1:0]     alu_portA,
    output logic [WORD-1:0]     alu_portB,
    input  logic [WORD-1:0]     alu_result,
    input  logic                alu_zero,
    input  logic                alu_neg,
    input  logic                alu_ovf
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner;
    aluop_t          op_q;
    word_t           a_q;
    word_t           b_q;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   win_idx;
    logic            accept;
    aluop_t          sel_op;
    word_t           sel_a;
    word_t           sel_b;
    logic [PW-1:0]   next_ptr;

    alu_arbiter_rr_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    assign req_ready = (state == ARB_IDLE) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign next_ptr  = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);

    always_comb begin
        sel_op = ALU_ADD;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_op = aluop_t'(req_op[4*i +: 4]);
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
            end
        end
    end

    assign alu_aluop = op_q;
    assign alu_portA = a_q;
    assign alu_portB = b_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ARB_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            op_q       <= ALU_ADD;
            a_q        <= '0;
            b_q        <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_neg    <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_valid  <= '0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        owner <= win_idx;
                        op_q  <= sel_op;
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        busy  <= 1'b1;
                        state <= ARB_EXEC;
                    end
                end
                ARB_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_neg    <= alu_neg;
                    rsp_ovf    <= alu_ovf;
                    rr_ptr     <= next_ptr;
                    rsp_valid  <= NREQ'(1) << owner;
                    state      <= ARB_RESP;
                end
                ARB_RESP: begin
                    // Only the owner's ready completes the handshake.
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state     <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: NREQ=2 and NREQ=3 instances, each driving a behavioural ALU.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    typedef struct {
        aluop_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        n;
        logic        o;
    } vec_t;

    typedef struct {
        int          owner;
        logic [31:0] res;
        logic        z;
        logic        n;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    logic [1:0]  a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [7:0]  a_req_op;
    logic [63:0] a_req_a, a_req_b;
    logic [31:0] a_rsp_result, a_alu_portA, a_alu_portB, a_alu_result;
    logic        a_rsp_zero, a_rsp_neg, a_rsp_ovf, a_busy;
    logic [3:0]  a_alu_aluop;
    logic        a_alu_zero, a_alu_neg, a_alu_ovf;

    logic [2:0]  b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [11:0] b_req_op;
    logic [95:0] b_req_a, b_req_b;
    logic [31:0] b_rsp_result, b_alu_portA, b_alu_portB, b_alu_result;
    logic        b_rsp_zero, b_rsp_neg, b_rsp_ovf, b_busy;
    logic [3:0]  b_alu_aluop;
    logic        b_alu_zero, b_alu_neg, b_alu_ovf;

    alu_arbiter #(.NREQ(2), .WORD(32)) dut_a (
        .CLK(clk), .RST(rst),
        .req_valid(a_req_valid), .req_op(a_req_op), .req_a(a_req_a), .req_b(a_req_b),
        .req_ready(a_req_ready), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_result(a_rsp_result), .rsp_zero(a_rsp_zero), .rsp_neg(a_rsp_neg),
        .rsp_ovf(a_rsp_ovf), .busy(a_busy),
        .alu_aluop(a_alu_aluop), .alu_portA(a_alu_portA), .alu_portB(a_alu_portB),
        .alu_result(a_alu_result), .alu_zero(a_alu_zero), .alu_neg(a_alu_neg),
        .alu_ovf(a_alu_ovf)
    );

    alu_arbiter #(.NREQ(3), .WORD(32)) dut_b (
        .CLK(clk), .RST(rst),
        .req_valid(b_req_valid), .req_op(b_req_op), .req_a(b_req_a), .req_b(b_req_b),
        .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_result(b_rsp_result), .rsp_zero(b_rsp_zero), .rsp_neg(b_rsp_neg),
        .rsp_ovf(b_rsp_ovf), .busy(b_busy),
        .alu_aluop(b_alu_aluop), .alu_portA(b_alu_portA), .alu_portB(b_alu_portB),
        .alu_result(b_alu_result), .alu_zero(b_alu_zero), .alu_neg(b_alu_neg),
        .alu_ovf(b_alu_ovf)
    );

    // External ALU stand-in: returns {ovf, neg, zero, result}.
    function automatic logic [34:0] alu_model(input logic [3:0] op, input logic [31:0] x,
                                              input logic [31:0] y);
        logic [31:0] r;
        logic        o;
        r = '0;
        o = 1'b0;
        if (op == ALU_ADD) begin
            r = x + y;
            o = (x[31] == y[31]) && (r[31] != x[31]);
        end else if (op == ALU_SUB) begin
            r = x - y;
            o = (x[31] != y[31]) && (r[31] != x[31]);
        end else if (op == ALU_AND) r = x & y;
        else if (op == ALU_OR)      r = x | y;
        else if (op == ALU_XOR)     r = x ^ y;
        return {o, r[31], (r == 32'd0), r};
    endfunction

    always_comb {a_alu_ovf, a_alu_neg, a_alu_zero, a_alu_result} =
        alu_model(a_alu_aluop, a_alu_portA, a_alu_portB);
    always_comb {b_alu_ovf, b_alu_neg, b_alu_zero, b_alu_result} =
        alu_model(b_alu_aluop, b_alu_portA, b_alu_portB);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int sel, input int r, input vec_t v);
        if (sel == 0) begin
            a_req_op[4*r +: 4]  = v.op;
            a_req_a[32*r +: 32] = v.a;
            a_req_b[32*r +: 32] = v.b;
        end else begin
            b_req_op[4*r +: 4]  = v.op;
            b_req_a[32*r +: 32] = v.a;
            b_req_b[32*r +: 32] = v.b;
        end
    endtask

    task automatic wait_grant(input int sel, output int who);
        logic [2:0] g;
        who = -1;
        for (int c = 0; c < 20; c++) begin
            #1;
            g = (sel == 0) ? {1'b0, a_req_ready & a_req_valid} : (b_req_ready & b_req_valid);
            if (g != 3'b000) begin
                chk("grant_onehot", 32'($onehot(g)), 32'd1);
                for (int i = 0; i < 3; i++) if (g[i]) who = i;
                break;
            end
            step();
        end
        if (who < 0) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic rsp_check(input int sel);
        exp_t        e;
        logic [2:0]  v;
        logic [31:0] r;
        logic [2:0]  f;
        v = (sel == 0) ? {1'b0, a_rsp_valid} : b_rsp_valid;
        r = (sel == 0) ? a_rsp_result : b_rsp_result;
        f = (sel == 0) ? {a_rsp_zero, a_rsp_neg, a_rsp_ovf} : {b_rsp_zero, b_rsp_neg, b_rsp_ovf};
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("rsp_valid", 32'(v), 32'(3'b001 << e.owner));
        chk("rsp_result", r, e.res);
        chk("rsp_flags", 32'(f), 32'({e.z, e.n, e.o}));
    endtask

    // Accept, check EXEC cycle, then check response in cycle N+2.
    task automatic run_txn(input int sel, input int exp_who, input vec_t v);
        int who;
        wait_grant(sel, who);
        chk("grant_idx", 32'(who), 32'(exp_who));
        sb.push_back('{exp_who, v.res, v.z, v.n, v.o});
        step();
        chk("exec_ready", (sel == 0) ? 32'(a_req_ready) : 32'(b_req_ready), 32'd0);
        chk("exec_busy", (sel == 0) ? 32'(a_busy) : 32'(b_busy), 32'd1);
        chk("exec_porta", (sel == 0) ? a_alu_portA : b_alu_portA, v.a);
        step();
        rsp_check(sel);
    endtask

    vec_t tv[7];
    vec_t v0, v1, v2, vx;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{ALU_ADD, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0};
        tv[1] = '{ALU_SUB, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b0, 1'b1};
        tv[2] = '{ALU_SUB, 32'd3,          32'd3,          32'd0,          1'b1, 1'b0, 1'b0};
        tv[3] = '{ALU_ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1, 1'b1};
        tv[4] = '{ALU_AND, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  1'b0, 1'b0, 1'b0};
        tv[5] = '{ALU_XOR, 32'd5,          32'd5,          32'd0,          1'b1, 1'b0, 1'b0};
        tv[6] = '{ALU_OR,  32'h8000_0000,  32'd0,          32'h8000_0000,  1'b0, 1'b1, 1'b0};
        v0 = '{ALU_ADD, 32'd1,    32'd2,    32'd3,          1'b0, 1'b0, 1'b0};
        v1 = '{ALU_SUB, 32'd10,   32'd4,    32'd6,          1'b0, 1'b0, 1'b0};
        v2 = '{ALU_XOR, 32'hFF,   32'h0F,   32'hF0,         1'b0, 1'b0, 1'b0};
        vx = '{ALU_SUB, 32'd1,    32'd2,    32'hFFFF_FFFF,  1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        a_req_valid = '0; a_req_op = '0; a_req_a = '0; a_req_b = '0; a_rsp_ready = '0;
        b_req_valid = '0; b_req_op = '0; b_req_a = '0; b_req_b = '0; b_rsp_ready = '0;
        step();
        step();
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(a_req_ready), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_result", a_rsp_result, 32'd0);
        chk("rst_flags", 32'({a_rsp_zero, a_rsp_neg, a_rsp_ovf}), 32'd0);
        chk("rst_latches", 32'(a_alu_aluop) | a_alu_portA | a_alu_portB, 32'd0);
        rst = 1'b0;
        step();

        // Table-driven single-requester transactions on req0.
        a_rsp_ready = 2'b11;
        a_req_valid = 2'b01;
        for (int t = 0; t < 7; t++) begin
            drive(0, 0, tv[t]);
            run_txn(0, 0, tv[t]);
        end

        // Both requesters held valid: alternation 0,1,0,1 from a fresh pointer.
        a_req_valid = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 0, v0);
        drive(0, 1, v1);
        a_req_valid = 2'b11;
        for (int t = 0; t < 4; t++) run_txn(0, t % 2, (t % 2 == 0) ? v0 : v1);

        // Backpressure in RESP with req1 waiting.
        a_req_valid = 2'b00;
        step();
        a_rsp_ready = 2'b00;
        drive(0, 0, '{ALU_ADD, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0, 1'b0});
        a_req_valid = 2'b01;
        run_txn(0, 0, '{ALU_ADD, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0, 1'b0});
        drive(0, 1, '{ALU_SUB, 32'd9, 32'd2, 32'd7, 1'b0, 1'b0, 1'b0});
        a_req_valid = 2'b10;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("hold_rsp_valid", 32'(a_rsp_valid), 32'd1);
            chk("hold_result", a_rsp_result, 32'd42);
            chk("hold_req_ready", 32'(a_req_ready), 32'd0);
            chk("hold_busy", 32'(a_busy), 32'd1);
            step();
        end
        a_rsp_ready = 2'b01;
        step();
        #1;
        chk("release_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("release_busy", 32'(a_busy), 32'd0);
        chk("release_req_ready", 32'(a_req_ready), 32'd2);
        a_rsp_ready = 2'b00;
        run_txn(0, 1, '{ALU_SUB, 32'd9, 32'd2, 32'd7, 1'b0, 1'b0, 1'b0});
        a_req_valid = 2'b00;
        a_rsp_ready = 2'b11;
        step();

        // Reset while EXEC: transaction dropped, pointer back to 0.
        drive(0, 1, v0);
        a_req_valid = 2'b10;
        begin
            int who;
            wait_grant(0, who);
            chk("t5_grant", 32'(who), 32'd1);
        end
        step();
        chk("t5_in_exec", 32'(a_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("t5_rst_busy", 32'(a_busy), 32'd0);
        chk("t5_rst_latch", a_alu_portA, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("t5_after_rsp_valid", 32'(a_rsp_valid), 32'd0);
        a_req_valid = 2'b11;
        #1;
        chk("t5_ptr_reset", 32'(a_req_ready), 32'd1);
        a_req_valid = 2'b10;
        drive(0, 1, vx);
        run_txn(0, 1, vx);
        a_req_valid = 2'b00;
        step();

        // NREQ=3: wrap 0,1,2,0; non-owner ready must not complete the handshake.
        drive(1, 0, v0);
        drive(1, 1, vx);
        drive(1, 2, v2);
        b_req_valid = 3'b111;
        for (int t = 0; t < 4; t++) begin
            run_txn(1, t % 3, (t % 3 == 0) ? v0 : ((t % 3 == 1) ? vx : v2));
            b_rsp_ready = ~(3'b001 << (t % 3));
            for (int c = 0; c < 2; c++) begin
                step();
                chk("nonowner_rsp_valid", 32'(b_rsp_valid), 32'(3'b001 << (t % 3)));
                chk("nonowner_busy", 32'(b_busy), 32'd1);
            end
            b_rsp_ready = 3'b001 << (t % 3);
            step();
            b_rsp_ready = 3'b000;
        end
        b_req_valid = 3'b000;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
